// File: rtl/pp_pipeline_accel_ctrl_pkg.sv
// pp_pipeline_accel_ctrl_pkg: shared FSM encoding and default sizing for the start-token readers
package pp_pipeline_accel_ctrl_pkg;
   typedef enum logic {S_IDLE = 1'b0, S_FWD = 1'b1} state_t;
   localparam int DEF_MAX_OUTSTANDING = 3;
   localparam int DEF_CNT_WIDTH = 4;
endpackage

// File: rtl/pp_pipeline_accel_task_counter.sv
// pp_pipeline_accel_task_counter: tasks-in-flight counter; ports clk/rst_n, inc/dec events, count, at_max, underflow
module pp_pipeline_accel_task_counter #(
   parameter int MAX = 3,
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         at_max,
   output logic         underflow
);
   assign at_max = count == W'(MAX);
   assign underflow = dec & (count == '0);
   always_ff @(posedge clk)
      if (!rst_n) count <= '0;
      else if (inc & ~dec) count <= count + W'(1);
      else if (dec & ~inc & (count != '0)) count <= count - W'(1);
endmodule

// File: rtl/pp_pipeline_accel_start_reader.sv
// pp_pipeline_accel_start_reader: pops upstream start tokens into ap_ctrl_hs starts, forwards one token per task, bounds tasks in flight
// ports: ap_clk/ap_rst_n; start_empty_n/start_read (upstream FIFO); start_out_full_n/start_out_write (downstream FIFO);
//        proc_ap_start/proc_ap_ready/proc_ap_done (process); outstanding, busy, err_spurious_done (status)
module pp_pipeline_accel_start_reader
   import pp_pipeline_accel_ctrl_pkg::*;
#(
   parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
   input  logic                 ap_clk,
   input  logic                 ap_rst_n,
   input  logic                 start_empty_n,
   output logic                 start_read,
   input  logic                 start_out_full_n,
   output logic                 start_out_write,
   output logic                 proc_ap_start,
   input  logic                 proc_ap_ready,
   input  logic                 proc_ap_done,
   output logic [CNT_WIDTH-1:0] outstanding,
   output logic                 busy,
   output logic                 err_spurious_done
);
   state_t state;
   logic at_max, underflow;
   pp_pipeline_accel_task_counter #(.MAX(MAX_OUTSTANDING), .W(CNT_WIDTH)) u_cnt (
      .clk(ap_clk), .rst_n(ap_rst_n), .inc(start_read), .dec(proc_ap_done),
      .count(outstanding), .at_max(at_max), .underflow(underflow)
   );
   // once the downstream token is written, the start no longer depends on downstream space
   assign proc_ap_start = start_empty_n & ~at_max & ((state == S_FWD) | start_out_full_n);
   assign start_out_write = proc_ap_start & (state == S_IDLE);
   assign start_read = proc_ap_start & proc_ap_ready;
   assign busy = (outstanding != '0) | (state == S_FWD);
   always_ff @(posedge ap_clk)
      if (!ap_rst_n) begin
         state <= S_IDLE;
         err_spurious_done <= 1'b0;
      end else begin
         state <= (state == S_IDLE) ? ((start_out_write & ~proc_ap_ready) ? S_FWD : S_IDLE)
                                    : (start_read ? S_IDLE : S_FWD);
         if (underflow) err_spurious_done <= 1'b1;
      end
endmodule

// File: tb/tb_pp_pipeline_accel_start_reader.sv
// tb_pp_pipeline_accel_start_reader: directed self-checking bench for the start-token reader
module tb_pp_pipeline_accel_start_reader;
   logic ap_clk = 1'b0, ap_rst_n = 1'b0;
   logic start_empty_n = 1'b0, start_out_full_n = 1'b0, proc_ap_ready = 1'b0, proc_ap_done = 1'b0;
   logic start_read, start_out_write, proc_ap_start, busy, err_spurious_done;
   logic [3:0] outstanding;
   int n_checks = 0, n_fails = 0, n_writes = 0;
   pp_pipeline_accel_start_reader dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start_empty_n(start_empty_n), .start_read(start_read),
      .start_out_full_n(start_out_full_n), .start_out_write(start_out_write), .proc_ap_start(proc_ap_start),
      .proc_ap_ready(proc_ap_ready), .proc_ap_done(proc_ap_done), .outstanding(outstanding),
      .busy(busy), .err_spurious_done(err_spurious_done)
   );
   always #5 ap_clk = ~ap_clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic cyc();
      @(posedge ap_clk);
      #1;
   endtask
   initial begin
      cyc(); cyc();
      ap_rst_n = 1'b1;
      #1;
      chk("rst_outstanding", outstanding, 0);
      chk("rst_err", err_spurious_done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_start", proc_ap_start, 0);
      chk("rst_write", start_out_write, 0);
      chk("rst_read", start_read, 0);
      cyc();
      // single task
      start_empty_n = 1; start_out_full_n = 1; proc_ap_ready = 1;
      #1;
      chk("single_start", proc_ap_start, 1);
      chk("single_write", start_out_write, 1);
      chk("single_read", start_read, 1);
      cyc();
      start_empty_n = 0; proc_ap_ready = 0;
      #1;
      chk("single_out1", outstanding, 1);
      chk("single_busy1", busy, 1);
      chk("single_start_off", proc_ap_start, 0);
      proc_ap_done = 1;
      cyc();
      proc_ap_done = 0;
      #1;
      chk("single_out0", outstanding, 0);
      chk("single_busy0", busy, 0);
      // ready stall for 5 cycles
      start_empty_n = 1;
      for (int k = 0; k < 6; k++) begin
         proc_ap_ready = (k == 5);
         #1;
         if (start_out_write) n_writes++;
         chk("stall_start", proc_ap_start, 1);
         chk("stall_write", start_out_write, k == 0);
         chk("stall_read", start_read, k == 5);
         if (k > 0) chk("stall_busy", busy, 1);
         cyc();
      end
      start_empty_n = 0; proc_ap_ready = 0;
      #1;
      chk("stall_nwrites", n_writes, 1);
      chk("stall_out1", outstanding, 1);
      proc_ap_done = 1;
      cyc();
      proc_ap_done = 0;
      // downstream full
      start_empty_n = 1; start_out_full_n = 0; proc_ap_ready = 1;
      #1;
      chk("full_start", proc_ap_start, 0);
      chk("full_read", start_read, 0);
      chk("full_write", start_out_write, 0);
      cyc();
      start_out_full_n = 1; proc_ap_ready = 0;
      #1;
      chk("full_rise_start", proc_ap_start, 1);
      chk("full_rise_write", start_out_write, 1);
      cyc();
      start_out_full_n = 0;
      #1;
      chk("fwd_full_start", proc_ap_start, 1);
      chk("fwd_full_write", start_out_write, 0);
      cyc();
      proc_ap_ready = 1;
      #1;
      chk("fwd_full_read", start_read, 1);
      cyc();
      start_empty_n = 0; proc_ap_ready = 0; start_out_full_n = 1;
      #1;
      chk("full_out1", outstanding, 1);
      proc_ap_done = 1;
      cyc();
      proc_ap_done = 0;
      #1;
      chk("full_out0", outstanding, 0);
      // saturation
      start_empty_n = 1; proc_ap_ready = 1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("sat_read", start_read, 1);
         cyc();
      end
      chk("sat_out3", outstanding, 3);
      chk("sat_start0", proc_ap_start, 0);
      chk("sat_read0", start_read, 0);
      cyc();
      chk("sat_hold_start", proc_ap_start, 0);
      proc_ap_done = 1;
      #1;
      chk("sat_done_same_cycle", proc_ap_start, 0);
      cyc();
      #1;
      chk("sat_out2", outstanding, 2);
      chk("sat_reaccept_start", proc_ap_start, 1);
      chk("sat_reaccept_read", start_read, 1);
      cyc();
      proc_ap_done = 0; start_empty_n = 0;
      #1;
      chk("simul_out2", outstanding, 2);
      proc_ap_done = 1;
      cyc(); cyc();
      proc_ap_done = 0;
      #1;
      chk("drain_out0", outstanding, 0);
      chk("drain_err0", err_spurious_done, 0);
      proc_ap_done = 1;
      cyc();
      proc_ap_done = 0;
      #1;
      chk("spur_err", err_spurious_done, 1);
      chk("spur_out0", outstanding, 0);
      cyc();
      chk("spur_sticky", err_spurious_done, 1);
      // reset mid-stall
      start_empty_n = 1; proc_ap_ready = 1;
      cyc(); cyc();
      proc_ap_ready = 0;
      #1;
      chk("pre_rst_out2", outstanding, 2);
      chk("pre_rst_write", start_out_write, 1);
      cyc();
      #1;
      chk("pre_rst_fwd_write", start_out_write, 0);
      ap_rst_n = 0;
      cyc();
      ap_rst_n = 1; start_empty_n = 0;
      #1;
      chk("post_rst_out0", outstanding, 0);
      chk("post_rst_err0", err_spurious_done, 0);
      chk("post_rst_busy0", busy, 0);
      start_empty_n = 1;
      #1;
      chk("post_rst_idle_write", start_out_write, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
